// File: rtl/ttt_game_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_game_ctrl
//   Tic-tac-toe game controller sitting between uart_rx and uart_tx. Decodes
//   ASCII commands, owns the 3x3 board, alternates turns, detects win/draw and
//   sends an ASCII status reply for every accepted command.
//
//   Commands : '1'..'9' place the mover's mark, 'R'/'r' restart the game.
//   Replies  : 'X'/'O' legal move, 'W' win, 'D' draw, 'R' restart, '?' reject.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   rx_data_valid/byte   one-cycle strobe + received byte from uart_rx
//   tx_active, tx_done   uart_tx busy level / end-of-byte strobe
//   tx_data_valid/byte   one-cycle launch strobe + reply byte to uart_tx
//   board                cell c at [2c+1:2c]; 00 empty, 01 X, 10 O
//   turn                 player to move (0 = X, 1 = O)
//   game_over, winner    end-of-game flag, 00 none/draw, 01 X, 10 O
//   busy                 high whenever the controller is not idle
//
// Build option
//   TTT_CRLF_EN : every reply becomes three bytes (code, CR, LF), each
//                 launched only after the previous byte's tx_done.
// ---------------------------------------------------------------------------
module ttt_game_ctrl #(
  parameter int CELLS        = 9,
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_data_valid,
  input  logic [7:0]           rx_byte,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic                 tx_data_valid,
  output logic [7:0]           tx_byte,
  output logic [2*CELLS-1:0]   board,
  output logic                 turn,
  output logic                 game_over,
  output logic [1:0]           winner,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, UPDATE, EVAL, SEND, WAIT_DONE} state_t;

  localparam logic [1:0] MARK_EMPTY = 2'b00;
  localparam logic [1:0] MARK_X     = 2'b01;
  localparam logic [1:0] MARK_O     = 2'b10;

  localparam logic [7:0] CH_X   = 8'h58;
  localparam logic [7:0] CH_O   = 8'h4F;
  localparam logic [7:0] CH_REJ = 8'h3F;
  localparam logic [7:0] CH_R   = 8'h52;
  localparam logic [7:0] CH_W   = 8'h57;
  localparam logic [7:0] CH_D   = 8'h44;
`ifdef TTT_CRLF_EN
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
`endif

  state_t     state;
  logic [7:0] cmd_byte;
  logic [7:0] reply;
`ifdef TTT_CRLF_EN
  logic [1:0] byte_idx;
`endif

  // True when mark m occupies any full row, column or diagonal of b.
  function automatic logic has_line(input logic [2*CELLS-1:0] b, input logic [1:0] m);
    logic [8:0] own;
    for (int i = 0; i < 9; i++) own[i] = (b[2*i +: 2] == m);
    return (own[0] & own[1] & own[2]) | (own[3] & own[4] & own[5]) |
           (own[6] & own[7] & own[8]) | (own[0] & own[3] & own[6]) |
           (own[1] & own[4] & own[7]) | (own[2] & own[5] & own[8]) |
           (own[0] & own[4] & own[8]) | (own[2] & own[4] & own[6]);
  endfunction

  // Command decode and the board as it would look after a legal move.
  logic               is_digit, is_restart, cell_empty, legal, mover_wins, board_full;
  logic [3:0]         cell_idx;
  logic [1:0]         mover_mark;
  logic [2*CELLS-1:0] next_board;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    is_digit   = (cmd_byte >= 8'h31) && (cmd_byte <= 8'h39);
    is_restart = (cmd_byte == 8'h52) || (cmd_byte == 8'h72);
    cell_idx   = cmd_byte[3:0] - 4'd1;  // '1'..'9' have low nibble 1..9
    mover_mark = turn ? MARK_O : MARK_X;
    next_board = board;
    cell_empty = 1'b0;
    for (int c = 0; c < CELLS; c++) begin
      if (4'(c) == cell_idx) begin
        cell_empty            = (board[2*c +: 2] == MARK_EMPTY);
        next_board[2*c +: 2]  = mover_mark;
      end
    end
    legal      = is_digit && cell_empty && !game_over;
    mover_wins = has_line(next_board, mover_mark);
    board_full = 1'b1;
    for (int c = 0; c < CELLS; c++) begin
      if (next_board[2*c +: 2] == MARK_EMPTY) board_full = 1'b0;
    end
  end

  assign busy = (state != IDLE);

  // The move is resolved entirely in UPDATE (win/draw evaluated on next_board)
  // so board and turn are visible two cycles after the command; EVAL then
  // loads the reply into the transmit register.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cmd_byte      <= 8'h00;
      reply         <= 8'h00;
      tx_data_valid <= 1'b0;
      tx_byte       <= 8'h00;
      board         <= '0;
      turn          <= FIRST_PLAYER;
      game_over     <= 1'b0;
      winner        <= 2'b00;
`ifdef TTT_CRLF_EN
      byte_idx      <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (rx_data_valid) begin
            cmd_byte <= rx_byte;
            state    <= UPDATE;
          end
        end

        UPDATE: begin
          if (is_restart) begin
            board     <= '0;
            turn      <= FIRST_PLAYER;
            game_over <= 1'b0;
            winner    <= 2'b00;
            reply     <= CH_R;
          end else if (legal) begin
            board <= next_board;
            if (mover_wins) begin
              game_over <= 1'b1;
              winner    <= mover_mark;
              reply     <= CH_W;
            end else if (board_full) begin
              game_over <= 1'b1;
              winner    <= 2'b00;
              reply     <= CH_D;
            end else begin
              turn  <= ~turn;
              reply <= turn ? CH_O : CH_X;
            end
          end else begin
            reply <= CH_REJ;
          end
          state <= EVAL;
        end

        EVAL: begin
          tx_byte       <= reply;
          tx_data_valid <= !tx_active;  // launch now unless uart_tx is still busy
          state         <= SEND;
`ifdef TTT_CRLF_EN
          byte_idx      <= 2'd0;
`endif
        end

        SEND: begin
          if (tx_data_valid) begin
            tx_data_valid <= 1'b0;
            state         <= WAIT_DONE;
          end else if (!tx_active) begin
            tx_data_valid <= 1'b1;
          end
        end

        WAIT_DONE: begin
          if (tx_done) begin
`ifdef TTT_CRLF_EN
            if (byte_idx == 2'd2) begin
              state <= IDLE;
            end else begin
              byte_idx      <= byte_idx + 2'd1;
              tx_byte       <= (byte_idx == 2'd0) ? CH_CR : CH_LF;
              tx_data_valid <= !tx_active;
              state         <= SEND;
            end
`else
            state <= IDLE;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
